// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : PC owner and ROM initiator with tagged responses, a one-entry
//               skid buffer and redirect flush, feeding decode over valid/stall.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 48,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  RomAddr,
    input  logic [INSTR_W-1:0] RomInstr,
    input  logic               StallD,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectPC,
    output logic [INSTR_W-1:0] InstrD,
    output logic [ADDR_W-1:0]  PCD,
    output logic               ValidD
);

    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_reset_pc   = RESET_PC & c_align_mask;
    localparam logic [ADDR_W-1:0] c_pc_step    = ADDR_W'(4);

    logic [ADDR_W-1:0]  r_pc;
    logic               r_req_valid;
    logic [ADDR_W-1:0]  r_req_pc;
    logic               r_valid_d;
    logic [INSTR_W-1:0] r_instr_d;
    logic [ADDR_W-1:0]  r_pc_d;
    logic               r_sk_valid;
    logic [INSTR_W-1:0] r_sk_instr;
    logic [ADDR_W-1:0]  r_sk_pc;

    logic       w_drain;
    logic       w_load;
    logic [1:0] w_occ;
    logic       w_issue;

    // Issue only while the in-flight response is guaranteed a slot even if
    // decode stalls forever: at most one entry held after this edge's drain.
    always_comb begin
        w_drain = r_valid_d & ~StallD;
        w_load  = ~r_valid_d | ~StallD;
        w_occ   = {1'b0, r_valid_d} + {1'b0, r_sk_valid} + {1'b0, r_req_valid};
        w_issue = (w_occ <= (2'd1 + {1'b0, w_drain}));
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pc        <= c_reset_pc;
            r_req_valid <= 1'b0;
            r_req_pc    <= '0;
            r_valid_d   <= 1'b0;
            r_instr_d   <= '0;
            r_pc_d      <= '0;
            r_sk_valid  <= 1'b0;
            r_sk_instr  <= '0;
            r_sk_pc     <= '0;
        end else if (Redirect) begin
            r_pc        <= RedirectPC & c_align_mask;
            r_req_valid <= 1'b0;
            r_valid_d   <= 1'b0;
            r_sk_valid  <= 1'b0;
        end else begin
            r_req_valid <= w_issue;
            if (w_issue) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + c_pc_step;
            end

            if (w_load) begin
                if (r_sk_valid) begin
                    r_instr_d <= r_sk_instr;
                    r_pc_d    <= r_sk_pc;
                end else if (r_req_valid) begin
                    r_instr_d <= RomInstr;
                    r_pc_d    <= r_req_pc;
                end
                r_valid_d  <= r_sk_valid | r_req_valid;
                r_sk_valid <= r_sk_valid & r_req_valid;
                if (r_sk_valid && r_req_valid) begin
                    r_sk_instr <= RomInstr;
                    r_sk_pc    <= r_req_pc;
                end
            end else if (r_req_valid) begin
                // Stalled: skid is known empty here, so the response parks in it.
                r_sk_valid <= 1'b1;
                r_sk_instr <= RomInstr;
                r_sk_pc    <= r_req_pc;
            end
        end
    end

    assign RomAddr = r_pc;
    assign InstrD  = r_instr_d;
    assign PCD     = r_pc_d;
    assign ValidD  = r_valid_d;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed vector table plus randomized run against a stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int          ADDR_W   = 32;
    localparam int          INSTR_W  = 48;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic               CLK = 1'b0;
    logic               Reset;
    logic [ADDR_W-1:0]  RomAddr;
    logic [INSTR_W-1:0] RomInstr;
    logic               StallD;
    logic               Redirect;
    logic [ADDR_W-1:0]  RedirectPC;
    logic [INSTR_W-1:0] InstrD;
    logic [ADDR_W-1:0]  PCD;
    logic               ValidD;

    always #5 CLK = ~CLK;

    instruction_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .RomAddr    (RomAddr),
        .RomInstr   (RomInstr),
        .StallD     (StallD),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .ValidD     (ValidD)
    );

    function automatic logic [47:0] word(input logic [31:0] a);
        case (a)
            32'd0:   word = 48'hE023C000000F;
            32'd4:   word = 48'hE14004000005;
            32'd8:   word = 48'hE2C004000064;
            32'd12:  word = 48'hEA408E000000;
            32'd16:  word = 48'hEC3086000000;
            default: word = {16'hC0DE, a};
        endcase
    endfunction

    // Synchronous ROM: data for the address seen at the previous edge.
    always @(posedge CLK) RomInstr <= word(RomAddr);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: next PC decode must see, and edges since the last flush.
    logic [31:0] m_head;
    int          m_n;
    logic        m_zero;

    task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] p);
        Reset      = r;
        StallD     = s;
        Redirect   = d;
        RedirectPC = p;
        if (r) begin
            m_head = RESET_PC;
            m_n    = 0;
            m_zero = 1'b1;
        end else if (d) begin
            m_head = p & ~32'd3;
            m_n    = 0;
            m_zero = 1'b0;
        end else begin
            if (m_n >= 2 && !s) m_head = m_head + 32'd4;
            if (m_n < 2) m_n++;
            if (m_n >= 2) m_zero = 1'b0;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic mcheck();
        chk("m_valid", 64'(ValidD), 64'(m_n >= 2));
        chk("m_align", 64'(RomAddr[1:0]), 64'd0);
        if (ValidD) begin
            chk("m_pcd", 64'(PCD), 64'(m_head));
            chk("m_instr", 64'(InstrD), 64'(word(m_head)));
        end else if (m_zero) begin
            chk("m_zero_pcd", 64'(PCD), 64'd0);
            chk("m_zero_instr", 64'(InstrD), 64'd0);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epcd;
        logic [31:0] eaddr;
        logic        ezero;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic d, input logic [31:0] p,
                       input logic ev, input logic [31:0] epcd, input logic [31:0] eaddr,
                       input logic ez);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = d; v.rpc = p;
        v.ev = ev; v.epcd = epcd; v.eaddr = eaddr; v.ezero = ez;
        vecs.push_back(v);
    endtask

    initial begin
        Reset = 1'b1; StallD = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        m_head = RESET_PC; m_n = 0; m_zero = 1'b1;

        //  rst stall redir rpc            valid pcd           romaddr       zero
        add(1, 0, 0, 32'h0,          0, 32'h0,         32'h0,         1);
        add(1, 0, 0, 32'h0,          0, 32'h0,         32'h0,         1);
        add(1, 0, 0, 32'h0,          0, 32'h0,         32'h0,         1);
        add(0, 0, 0, 32'h0,          0, 32'h0,         32'h4,         1);
        add(0, 0, 0, 32'h0,          1, 32'h0,         32'h8,         0);
        add(0, 0, 0, 32'h0,          1, 32'h4,         32'hC,         0);
        add(0, 1, 0, 32'h0,          1, 32'h4,         32'hC,         0);
        add(0, 1, 0, 32'h0,          1, 32'h4,         32'hC,         0);
        add(0, 1, 0, 32'h0,          1, 32'h4,         32'hC,         0);
        add(0, 0, 0, 32'h0,          1, 32'h8,         32'h10,        0);
        add(0, 0, 0, 32'h0,          1, 32'hC,         32'h14,        0);
        add(0, 0, 0, 32'h0,          1, 32'h10,        32'h18,        0);
        add(0, 0, 1, 32'h0B,         0, 32'h0,         32'h8,         0);
        add(0, 0, 0, 32'h0,          0, 32'h0,         32'hC,         0);
        add(0, 0, 0, 32'h0,          1, 32'h8,         32'h10,        0);
        add(0, 0, 0, 32'h0,          1, 32'hC,         32'h14,        0);
        add(0, 1, 0, 32'h0,          1, 32'hC,         32'h14,        0);
        add(0, 1, 1, 32'h10,         0, 32'h0,         32'h10,        0);
        add(0, 1, 0, 32'h0,          0, 32'h0,         32'h14,        0);
        add(0, 1, 0, 32'h0,          1, 32'h10,        32'h18,        0);
        add(0, 1, 0, 32'h0,          1, 32'h10,        32'h18,        0);
        add(1, 1, 0, 32'h0,          0, 32'h0,         32'h0,         1);
        add(0, 0, 0, 32'h0,          0, 32'h0,         32'h4,         1);
        add(0, 0, 0, 32'h0,          1, 32'h0,         32'h8,         0);
        add(0, 0, 0, 32'h0,          1, 32'h4,         32'hC,         0);
        add(0, 0, 1, 32'hFFFFFFFC,   0, 32'h0,         32'hFFFFFFFC,  0);
        add(0, 0, 0, 32'h0,          0, 32'h0,         32'h0,         0);
        add(0, 0, 0, 32'h0,          1, 32'hFFFFFFFC,  32'h4,         0);
        add(0, 0, 0, 32'h0,          1, 32'h0,         32'h8,         0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            chk($sformatf("v%0d_valid", i), 64'(ValidD), 64'(vecs[i].ev));
            chk($sformatf("v%0d_romaddr", i), 64'(RomAddr), 64'(vecs[i].eaddr));
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_pcd", i), 64'(PCD), 64'(vecs[i].epcd));
                chk($sformatf("v%0d_instr", i), 64'(InstrD), 64'(word(vecs[i].epcd)));
            end
            if (vecs[i].ezero) begin
                chk($sformatf("v%0d_zero_pcd", i), 64'(PCD), 64'd0);
                chk($sformatf("v%0d_zero_instr", i), 64'(InstrD), 64'd0);
            end
            mcheck();
        end

        // Randomized run with stall bursts, redirects (some near the top of
        // the address space) and occasional resets.
        begin
            int burst = 0;
            for (int i = 0; i < 4000; i++) begin
                logic        r, s, d;
                logic [31:0] p;
                if (burst == 0 && $urandom_range(0, 30) == 0) burst = $urandom_range(2, 8);
                s = (burst > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
                if (burst > 0) burst--;
                r = ($urandom_range(0, 199) == 0);
                d = ($urandom_range(0, 24) == 0);
                p = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                                : 32'($urandom_range(0, 255));
                cyc(r, s, d, p);
                mcheck();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
